// File: rtl/imem_load_ctrl_if.sv
// Bus bundle between the instruction-memory load controller and its surroundings:
// the loader command/stream, the core fetch PC, the memory write port and status.
interface imem_load_ctrl_if #(
   parameter int DEPTH = 32,
   parameter int LEN_W = $clog2(DEPTH) + 1
);
   logic             load_req;
   logic [LEN_W-1:0] load_len;
   logic             s_valid;
   logic [31:0]      s_data;
   logic             s_ready;
   logic [31:0]      fetch_pc;
   logic [31:0]      imem_addr;
   logic             imem_we;
   logic [31:0]      imem_wdata;
   logic             core_stall;
   logic             busy;
   logic             done;
   logic             err;

   modport slave (
      input  load_req, load_len, s_valid, s_data, fetch_pc,
      output s_ready, imem_addr, imem_we, imem_wdata, core_stall, busy, done, err
   );

   modport master (
      output load_req, load_len, s_valid, s_data, fetch_pc,
      input  s_ready, imem_addr, imem_we, imem_wdata, core_stall, busy, done, err
   );
endinterface

// File: rtl/imem_load_ctrl.sv
// Boot-time program loader: streams words into instruction memory while the core
// is stalled, then hands the memory address port over to the fetch PC.
module imem_load_ctrl #(
   parameter int DEPTH = 32,
   parameter int LEN_W = $clog2(DEPTH) + 1
) (
   input  logic            clk,
   input  logic            rst,
   imem_load_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_FLUSH = 2'd2,
      S_RUN   = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_next;

   logic [LEN_W-1:0] r_cnt;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-2:0] r_widx;
   logic             r_we;
   logic [31:0]      r_wdata;
   logic             r_done;
   logic             r_err;

   logic             w_len_ok;
   logic             w_last;
   logic             w_hs;
   logic             w_start;
   logic             w_bad;

   assign w_len_ok = (bus.load_len != '0) && (bus.load_len <= LEN_W'(DEPTH));
   assign w_last   = (r_cnt == (r_len - LEN_W'(1)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Load commands are honoured only from IDLE or RUN; LOAD/FLUSH ignore them silently.
   always_comb begin
      w_next  = r_state;
      w_hs    = 1'b0;
      w_start = 1'b0;
      w_bad   = 1'b0;
      case (r_state)
         S_IDLE, S_RUN: begin
            if (bus.load_req) begin
               if (w_len_ok) begin
                  w_start = 1'b1;
                  w_next  = S_LOAD;
               end else begin
                  w_bad = 1'b1;
               end
            end
         end
         S_LOAD: begin
            w_hs = bus.s_valid;
            if (w_hs && w_last) begin
               w_next = S_FLUSH;
            end
         end
         S_FLUSH: begin
            w_next = S_RUN;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_len   <= '0;
         r_widx  <= '0;
         r_we    <= 1'b0;
         r_wdata <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_we   <= w_hs;
         r_done <= (r_state == S_FLUSH);
         r_err  <= w_bad;
         if (w_start) begin
            r_cnt  <= '0;
            r_len  <= bus.load_len;
            r_widx <= '0;
         end
         // Write is registered: the word accepted this cycle is written next cycle.
         if (w_hs) begin
            r_cnt   <= r_cnt + LEN_W'(1);
            r_widx  <= r_cnt[LEN_W-2:0];
            r_wdata <= bus.s_data;
         end
      end
   end

   always_comb begin
      bus.imem_addr = '0;
      case (r_state)
         S_LOAD, S_FLUSH: bus.imem_addr = {{(32-LEN_W-1){1'b0}}, r_widx, 2'b00};
         S_RUN:           bus.imem_addr = bus.fetch_pc;
         default:         bus.imem_addr = '0;
      endcase
   end

   assign bus.s_ready    = (r_state == S_LOAD);
   assign bus.core_stall = (r_state != S_RUN);
   assign bus.busy       = (r_state == S_LOAD) || (r_state == S_FLUSH);
   assign bus.imem_we    = r_we;
   assign bus.imem_wdata = r_wdata;
   assign bus.done       = r_done;
   assign bus.err        = r_err;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl with a behavioural instruction memory on the
// write port; expected values are hand-computed constants.
module tb_imem_load_ctrl;
   localparam int DEPTH = 32;
   localparam int LEN_W = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   logic rst = 1'b1;

   imem_load_ctrl_if #(.DEPTH(DEPTH), .LEN_W(LEN_W)) bus ();

   imem_load_ctrl #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [DEPTH];
   int unsigned wr_cnt   = 0;
   int unsigned done_cnt = 0;
   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   always @(posedge clk) begin
      if (bus.imem_we) begin
         mem[bus.imem_addr[$clog2(DEPTH)+1:2]] <= bus.imem_wdata;
         wr_cnt <= wr_cnt + 1;
      end
      if (bus.done) done_cnt <= done_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic exp_ctl(input string tag, input logic rdy, input logic stall,
                          input logic bsy, input logic dn, input logic er, input logic we);
      check({tag, "/s_ready"},    32'(bus.s_ready),    32'(rdy));
      check({tag, "/core_stall"}, 32'(bus.core_stall), 32'(stall));
      check({tag, "/busy"},       32'(bus.busy),       32'(bsy));
      check({tag, "/done"},       32'(bus.done),       32'(dn));
      check({tag, "/err"},        32'(bus.err),        32'(er));
      check({tag, "/imem_we"},    32'(bus.imem_we),    32'(we));
   endtask

   task automatic exp_wr(input string tag, input logic [31:0] addr, input logic [31:0] data);
      check({tag, "/we"},    32'(bus.imem_we), 32'd1);
      check({tag, "/addr"},  bus.imem_addr,    addr);
      check({tag, "/wdata"}, bus.imem_wdata,   data);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   logic [31:0] prog [3];
   int unsigned wr0;
   int unsigned dn0;

   initial begin
      prog[0] = 32'h05400413;
      prog[1] = 32'h03c00493;
      prog[2] = 32'h00940c63;
      bus.load_req = 1'b0;
      bus.load_len = '0;
      bus.s_valid  = 1'b0;
      bus.s_data   = '0;
      bus.fetch_pc = 32'h40;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      exp_ctl("rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("rst/addr", bus.imem_addr, 32'h0);
      check("rst/wdata", bus.imem_wdata, 32'h0);
      rst = 1'b0;
      tick;
      exp_ctl("idle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("idle/addr", bus.imem_addr, 32'h0);

      // continuous 3-word load
      wr0 = wr_cnt;
      bus.load_req = 1'b1;
      bus.load_len = LEN_W'(3);
      tick;
      bus.load_req = 1'b0;
      exp_ctl("c.load", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check("c.load/addr", bus.imem_addr, 32'h0);
      for (int i = 0; i < 3; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = prog[i];
         tick;
         exp_wr("c.wr", 32'(i * 4), prog[i]);
         check("c.s_ready", 32'(bus.s_ready), (i < 2) ? 32'd1 : 32'd0);
      end
      bus.s_valid = 1'b0;
      check("c.flush/busy", 32'(bus.busy), 32'd1);
      check("c.flush/done", 32'(bus.done), 32'd0);
      tick;
      exp_ctl("c.run", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("c.run/addr", bus.imem_addr, 32'h40);
      bus.fetch_pc = 32'h0000_0124;
      #1;
      check("c.run/addr2", bus.imem_addr, 32'h124);
      check("c.writes", wr_cnt - wr0, 32'd3);
      for (int i = 0; i < 3; i++) check("c.mem", mem[i], prog[i]);
      tick;
      check("c.done_pulse", 32'(bus.done), 32'd0);

      // stream data outside LOAD is dropped
      wr0 = wr_cnt;
      bus.s_valid = 1'b1;
      bus.s_data  = 32'hFFFF_FFFF;
      #1;
      check("run/s_ready", 32'(bus.s_ready), 32'd0);
      tick;
      bus.s_valid = 1'b0;
      check("run/no_we", 32'(bus.imem_we), 32'd0);

      // gapped 3-word load
      dn0 = done_cnt;
      bus.load_req = 1'b1;
      bus.load_len = LEN_W'(3);
      tick;
      bus.load_req = 1'b0;
      exp_ctl("g.load", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = prog[i];
         tick;
         bus.s_valid = 1'b0;
         exp_wr("g.wr", 32'(i * 4), prog[i]);
         if (i < 2) begin
            tick;
            check("g.gap1/we", 32'(bus.imem_we), 32'd0);
            check("g.gap1/s_ready", 32'(bus.s_ready), 32'd1);
            tick;
            check("g.gap2/we", 32'(bus.imem_we), 32'd0);
         end
      end
      check("g.flush/s_ready", 32'(bus.s_ready), 32'd0);
      tick;
      exp_ctl("g.run", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick;
      tick;
      check("g.writes", wr_cnt - wr0, 32'd3);
      check("g.done_cnt", done_cnt - dn0, 32'd1);

      // bad lengths from RUN
      wr0 = wr_cnt;
      bus.load_req = 1'b1;
      bus.load_len = LEN_W'(0);
      tick;
      bus.load_req = 1'b0;
      exp_ctl("bad0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick;
      check("bad0/err_pulse", 32'(bus.err), 32'd0);
      bus.load_req = 1'b1;
      bus.load_len = LEN_W'(DEPTH + 1);
      tick;
      bus.load_req = 1'b0;
      exp_ctl("bad33", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick;
      check("bad33/err_pulse", 32'(bus.err), 32'd0);
      check("bad/writes", wr_cnt - wr0, 32'd0);

      // full-depth load, with an ignored load_req mid-stream
      bus.load_req = 1'b1;
      bus.load_len = LEN_W'(DEPTH);
      tick;
      bus.load_req = 1'b0;
      check("f.load/busy", 32'(bus.busy), 32'd1);
      for (int i = 0; i < DEPTH; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 32'(i);
         if (i == 10) begin
            bus.load_req = 1'b1;
            bus.load_len = LEN_W'(1);
         end
         tick;
         bus.load_req = 1'b0;
         if (i == 0 || i == 10 || i == 11 || i >= DEPTH - 2) begin
            exp_wr("f.wr", 32'(i * 4), 32'(i));
            check("f.s_ready", 32'(bus.s_ready), (i < DEPTH - 1) ? 32'd1 : 32'd0);
         end
         if (i == 10) check("f.ignored/err", 32'(bus.err), 32'd0);
      end
      bus.s_valid = 1'b0;
      tick;
      exp_ctl("f.run", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("f.mem0", mem[0], 32'd0);
      check("f.mem11", mem[11], 32'd11);
      check("f.mem31", mem[31], 32'd31);

      // reload a single word from RUN
      bus.load_req = 1'b1;
      bus.load_len = LEN_W'(1);
      tick;
      bus.load_req = 1'b0;
      exp_ctl("r1.load", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      bus.s_valid = 1'b1;
      bus.s_data  = 32'hDEAD_BEEF;
      tick;
      bus.s_valid = 1'b0;
      exp_wr("r1.wr", 32'h0, 32'hDEAD_BEEF);
      exp_ctl("r1.flush", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      tick;
      exp_ctl("r1.run", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("r1.mem0", mem[0], 32'hDEAD_BEEF);
      check("r1.mem1", mem[1], 32'd1);

      // reset mid-load: third write in flight is discarded
      wr0 = wr_cnt;
      bus.load_req = 1'b1;
      bus.load_len = LEN_W'(4);
      tick;
      bus.load_req = 1'b0;
      bus.s_valid = 1'b1;
      bus.s_data  = 32'hA0;
      tick;
      bus.s_data  = 32'hA1;
      tick;
      bus.s_data  = 32'hA2;
      tick;
      bus.s_valid = 1'b0;
      exp_wr("rl.wr2", 32'h8, 32'hA2);
      #2;
      rst = 1'b1;
      #1;
      exp_ctl("rl.rst", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("rl.rst/addr", bus.imem_addr, 32'h0);
      check("rl.rst/wdata", bus.imem_wdata, 32'h0);
      bus.load_req = 1'b1;
      bus.load_len = LEN_W'(2);
      tick;
      bus.load_req = 1'b0;
      check("rl.req_in_rst/busy", 32'(bus.busy), 32'd0);
      check("rl.req_in_rst/s_ready", 32'(bus.s_ready), 32'd0);
      tick;
      rst = 1'b0;
      tick;
      exp_ctl("rl.idle", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("rl.writes", wr_cnt - wr0, 32'd2);
      check("rl.mem0", mem[0], 32'hA0);
      check("rl.mem1", mem[1], 32'hA1);
      check("rl.mem2", mem[2], 32'd2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/imem_load_ctrl.md
# imem_load_ctrl

Boot-time controller for the single-cycle processor's instruction memory. Sequences a program load from a word-stream source into the instruction memory, holding the core stalled until the load completes. Arbitrates the memory address port between the loader and the core fetch path. Sits between the fetch stage (PC), the instruction memory write port, and an external loader (UART/debug bridge).

## Interface
- DEPTH, 32, instruction memory depth in 32-bit words (power of two, ≥2)
- LEN_W, $clog2(DEPTH)+1, width of load length field

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- load_req  in  1  one-cycle pulse: start a program load
- load_len  in  LEN_W  number of words to load; sampled with load_req
- s_valid  in  1  stream word valid
- s_data  in  32  stream word (instruction)
- s_ready  out  1  controller accepts s_data this cycle
- fetch_pc  in  32  core PC (byte address)
- imem_addr  out  32  byte address to instruction memory (muxed)
- imem_we  out  1  instruction memory write enable (registered)
- imem_wdata  out  32  instruction memory write data (registered)
- core_stall  out  1  core must hold PC and suppress writeback
- busy  out  1  state is LOAD or FLUSH
- done  out  1  one-cycle pulse: load complete
- err  out  1  one-cycle pulse: load_req rejected

## Operation
- States: IDLE, LOAD, FLUSH, RUN. Reset state IDLE.
- IDLE: core_stall=1, s_ready=0, imem_addr=0.
- IDLE or RUN, load_req=1: if 1 ≤ load_len ≤ DEPTH → LOAD, cnt←0, len←load_len; else err=1 for one cycle, state unchanged.
- LOAD: s_ready=1, core_stall=1. Handshake (s_valid & s_ready) writes s_data to word index cnt; cnt increments. Handshake with cnt==len-1 → FLUSH. No handshake → stay, cnt held.
- FLUSH: s_ready=0; last write completes; → RUN, done=1 on entering RUN (first cycle of RUN).
- RUN: core_stall=0, s_ready=0, imem_addr=fetch_pc, imem_we=0.
- load_req in LOAD/FLUSH ignored (no err, no restart).
- s_valid outside LOAD ignored; data dropped, s_ready=0.
- imem_addr in LOAD/FLUSH = registered write address (wr_idx<<2); byte address, low two bits 0.
- cnt width LEN_W; write index = cnt[LEN_W-2:0]; cnt never exceeds len-1 so no wrap.
- Memory contents are not cleared by reset or by a new load; only loaded words change.

## Timing
- Reset (async assert): state=IDLE, cnt=0, imem_we=0, imem_wdata=0, imem_addr=0, s_ready=0, core_stall=1, busy=0, done=0, err=0. Deassertion synchronous to clk by integration.
- load_req at cycle T (valid) → LOAD, s_ready=1 at T+1.
- Handshake at cycle N → imem_we=1, imem_wdata, imem_addr=idx<<2 during N+1 (write commits at end of N+1).
- Back-to-back handshakes: one word per cycle, no bubbles.
- Last handshake at N → FLUSH at N+1 (last write), RUN and done=1 at N+2; core_stall falls at N+2.
- err asserted in cycle T+1 after bad load_req at T.
- Reset mid-load: immediate return to IDLE, in-flight registered write discarded (imem_we=0), previously written words retained, core stays stalled.

## Test plan
- Reset: assert rst mid-cycle → all outputs at reset values asynchronously, core_stall=1, state IDLE.
- Load 3 words (0x05400413, 0x03c00493, 0x00940c63), s_valid continuous → imem_we at addr 0x0,0x4,0x8 on consecutive cycles, done pulse 2 cycles after last handshake, then imem_addr follows fetch_pc.
- Gapped stream: same 3 words with s_valid low 2 cycles between each → cnt holds, writes only on handshakes, addresses 0x0/0x4/0x8, single done pulse.
- Bad length: load_req with load_len=0 and with load_len=DEPTH+1 → err one cycle each, state unchanged, no writes.
- Full load: load_len=DEPTH, words = index → last write at addr (DEPTH-1)*4, no wrap; reload from RUN with load_len=1 → only word 0 overwritten, core re-stalled during LOAD/FLUSH.
- Reset during LOAD after 2 of 4 words → imem_we drops immediately, IDLE, s_ready=0; words 0–1 retained; load_req ignored while rst high.
